wasm_operand_stack: RTL and testbench

- Parametrised, typed operand stack for the WebAssembly CPU core. It holds value/type pairs and serves push, pop and binary-op "replace" requests from the decoder/ALU.
- It exposes the top two entries combinationally for the ALU, plus empty/depth status and a sticky trap code.
- It generalises the CPU's single result/result_type/result_empty view to a DEPTH-entry stack with overflow/underflow trapping.

---
 rtl/wasm_operand_stack.sv | 145 ++++++++++++++
 tb/tb_wasm_operand_stack.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wasm_operand_stack.sv
// Typed operand stack for the WebAssembly core: push/pop/replace2 with sticky traps.
// Optional REPLACE2 type checking is enabled by defining WASM_STACK_TYPECHECK_EN.
module wasm_operand_stack #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_value,
  input  logic [1:0]       in_type,
  output logic             ready,
  output logic [WIDTH-1:0] top,
  output logic [1:0]       top_type,
  output logic [WIDTH-1:0] second,
  output logic [1:0]       second_type,
  output logic             empty,
  output logic [CNT_W-1:0] depth,
  output logic [2:0]       trap
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_REP2 = 2'd3;

  localparam logic [2:0] TRAP_NONE = 3'd0;
  localparam logic [2:0] TRAP_OVF  = 3'd1;
  localparam logic [2:0] TRAP_UDF  = 3'd2;
  localparam logic [2:0] TRAP_TYPE = 3'd3;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  logic [WIDTH-1:0] vals  [DEPTH];
  logic [1:0]       types [DEPTH];

  logic [CNT_W-1:0] depth_q, depth_d;
  logic [2:0]       trap_q, trap_d;

  logic [AW-1:0]    push_idx, top_idx, second_idx;
  logic             is_empty, is_full, has_two;
  logic             type_bad;

  logic             wr_en;
  logic [AW-1:0]    wr_idx;

  assign push_idx   = AW'(depth_q);
  assign top_idx    = AW'(depth_q - CNT_ONE);
  assign second_idx = AW'(depth_q - CNT_TWO);

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == CNT_FULL);
  assign has_two  = (depth_q >= CNT_TWO);

  assign ready = (trap_q == TRAP_NONE);
  assign empty = is_empty;
  assign depth = depth_q;
  assign trap  = trap_q;

  // Read ports are masked so stale array contents never leak out.
  always_comb begin
    top         = '0;
    top_type    = '0;
    second      = '0;
    second_type = '0;
    if (!is_empty) begin
      top      = vals[top_idx];
      top_type = types[top_idx];
    end
    if (has_two) begin
      second      = vals[second_idx];
      second_type = types[second_idx];
    end
  end

`ifdef WASM_STACK_TYPECHECK_EN
  assign type_bad = (top_type != second_type) ||
                    (in_type != top_type);
`else
  assign type_bad = 1'b0;
`endif

  always_comb begin
    depth_d = depth_q;
    trap_d  = trap_q;
    wr_en   = 1'b0;
    wr_idx  = push_idx;
    if (ready && !reset) begin
      unique case (op)
        OP_PUSH: begin
          if (is_full) begin
            trap_d = TRAP_OVF;
          end else begin
            wr_en   = 1'b1;
            depth_d = depth_q + CNT_ONE;
          end
        end
        OP_POP: begin
          if (is_empty) begin
            trap_d = TRAP_UDF;
          end else begin
            depth_d = depth_q - CNT_ONE;
          end
        end
        // Underflow takes precedence over a type mismatch.
        OP_REP2: begin
          if (!has_two) begin
            trap_d = TRAP_UDF;
          end else if (type_bad) begin
            trap_d = TRAP_TYPE;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = second_idx;
            depth_d = depth_q - CNT_ONE;
          end
        end
        OP_NOP: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      trap_q  <= TRAP_NONE;
    end else begin
      depth_q <= depth_d;
      trap_q  <= trap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      vals[wr_idx]  <= in_value;
      types[wr_idx] <= in_type;
    end
  end

endmodule

// File: tb/tb_wasm_operand_stack.sv
// Directed vector bench for wasm_operand_stack (DEPTH=16, WIDTH=64).
module tb_wasm_operand_stack;

  localparam int WIDTH = 64;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  localparam logic [1:0] NOP  = 2'd0;
  localparam logic [1:0] PUSH = 2'd1;
  localparam logic [1:0] POP  = 2'd2;
  localparam logic [1:0] REP2 = 2'd3;

  localparam logic [1:0] T_I32 = 2'd0;
  localparam logic [1:0] T_I64 = 2'd1;
  localparam logic [1:0] T_F64 = 2'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       op;
  logic [WIDTH-1:0] in_value;
  logic [1:0]       in_type;
  logic             ready;
  logic [WIDTH-1:0] top;
  logic [1:0]       top_type;
  logic [WIDTH-1:0] second;
  logic [1:0]       second_type;
  logic             empty;
  logic [CNT_W-1:0] depth;
  logic [2:0]       trap;

  wasm_operand_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .op(op),
    .in_value(in_value),
    .in_type(in_type),
    .ready(ready),
    .top(top),
    .top_type(top_type),
    .second(second),
    .second_type(second_type),
    .empty(empty),
    .depth(depth),
    .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic [1:0]       op;
    logic [WIDTH-1:0] val;
    logic [1:0]       typ;
    logic [CNT_W-1:0] e_depth;
    logic [WIDTH-1:0] e_top;
    logic [1:0]       e_ttype;
    logic [WIDTH-1:0] e_second;
    logic [2:0]       e_trap;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(
    input logic rst, input logic [1:0] o,
    input logic [WIDTH-1:0] v, input logic [1:0] t,
    input int d, input logic [WIDTH-1:0] tp,
    input logic [1:0] tt, input logic [WIDTH-1:0] sc,
    input logic [2:0] tr
  );
    vec_t r;
    r.rst = rst; r.op = o; r.val = v; r.typ = t;
    r.e_depth = CNT_W'(d); r.e_top = tp; r.e_ttype = tt;
    r.e_second = sc; r.e_trap = tr;
    return r;
  endfunction

  task automatic chk(input string name, input longint act,
                     input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic rst, input logic [1:0] o,
                      input logic [WIDTH-1:0] v, input logic [1:0] t);
    @(negedge clk);
    reset = rst; op = o; in_value = v; in_type = t;
    @(posedge clk);
    #1;
    reset = 1'b0; op = NOP;
  endtask

  task automatic check_state(input string tag, input vec_t e);
    chk({tag, ".depth"}, longint'(depth), longint'(e.e_depth));
    chk({tag, ".top"}, longint'(top), longint'(e.e_top));
    chk({tag, ".top_type"}, longint'(top_type), longint'(e.e_ttype));
    chk({tag, ".second"}, longint'(second), longint'(e.e_second));
    chk({tag, ".trap"}, longint'(trap), longint'(e.e_trap));
    chk({tag, ".ready"}, longint'(ready),
        longint'(e.e_trap == 3'd0));
    chk({tag, ".empty"}, longint'(empty),
        longint'(e.e_depth == '0));
  endtask

  initial begin
    reset = 1'b1; op = NOP; in_value = '0; in_type = '0;

    vq.push_back(mk(1, NOP,  0, T_I32, 0, 0, T_I32, 0, 0));
    vq.push_back(mk(0, PUSH, 1, T_I64, 1, 1, T_I64, 0, 0));
    vq.push_back(mk(0, PUSH, 2, T_I64, 2, 2, T_I64, 1, 0));
    vq.push_back(mk(0, REP2, 3, T_I64, 1, 3, T_I64, 0, 0));
    vq.push_back(mk(0, NOP,  9, T_I64, 1, 3, T_I64, 0, 0));
    vq.push_back(mk(1, NOP,  0, T_I32, 0, 0, T_I32, 0, 0));
    vq.push_back(mk(0, POP,  0, T_I32, 0, 0, T_I32, 0, 2));
    vq.push_back(mk(0, PUSH, 5, T_I64, 0, 0, T_I32, 0, 2));
    vq.push_back(mk(1, NOP,  0, T_I32, 0, 0, T_I32, 0, 0));
    vq.push_back(mk(0, PUSH, 7, T_I32, 1, 7, T_I32, 0, 0));
    vq.push_back(mk(0, REP2, 9, T_I32, 1, 7, T_I32, 0, 2));
    vq.push_back(mk(1, NOP,  0, T_I32, 0, 0, T_I32, 0, 0));
    vq.push_back(mk(0, PUSH, 1, T_I32, 1, 1, T_I32, 0, 0));
    vq.push_back(mk(0, PUSH, 2, T_I64, 2, 2, T_I64, 1, 0));
`ifdef WASM_STACK_TYPECHECK_EN
    vq.push_back(mk(0, REP2, 3, T_I64, 2, 2, T_I64, 1, 3));
`else
    vq.push_back(mk(0, REP2, 3, T_I64, 1, 3, T_I64, 0, 0));
`endif
    vq.push_back(mk(1, NOP,  0, T_I32, 0, 0, T_I32, 0, 0));
    vq.push_back(mk(0, PUSH, 10, T_F64, 1, 10, T_F64, 0, 0));
    vq.push_back(mk(0, PUSH, 11, T_F64, 2, 11, T_F64, 10, 0));
    vq.push_back(mk(0, PUSH, 12, T_F64, 3, 12, T_F64, 11, 0));
    vq.push_back(mk(0, POP,  0, T_I32, 2, 11, T_F64, 10, 0));
    vq.push_back(mk(0, PUSH, 14, T_I64, 3, 14, T_I64, 11, 0));
    vq.push_back(mk(1, PUSH, 13, T_I64, 0, 0, T_I32, 0, 0));
    vq.push_back(mk(0, POP,  0, T_I32, 0, 0, T_I32, 0, 2));
    vq.push_back(mk(0, REP2, 0, T_I32, 0, 0, T_I32, 0, 2));
    vq.push_back(mk(1, NOP,  0, T_I32, 0, 0, T_I32, 0, 0));

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].op, vq[i].val, vq[i].typ);
      check_state($sformatf("vec%0d", i), vq[i]);
    end

    // Fill to capacity, then overflow; trap 1 must stick.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, PUSH, WIDTH'(i), T_I64);
    check_state("full", mk(0, NOP, 0, 0, 16, 15, T_I64, 14, 0));
    step(1'b0, PUSH, 64'hdead, T_I64);
    check_state("ovf", mk(0, NOP, 0, 0, 16, 15, T_I64, 14, 1));
    step(1'b0, POP, 0, T_I32);
    check_state("ovf_sticky", mk(0, NOP, 0, 0, 16, 15, T_I64, 14, 1));
    step(1'b1, NOP, 0, T_I32);
    check_state("ovf_reset", mk(0, NOP, 0, 0, 0, 0, T_I32, 0, 0));

    // Drain a full stack back to empty, then underflow.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, PUSH, WIDTH'(100 + i), T_I32);
    for (int i = 0; i < DEPTH - 1; i++)
      step(1'b0, POP, 0, T_I32);
    check_state("drain1", mk(0, NOP, 0, 0, 1, 100, T_I32, 0, 0));
    step(1'b0, POP, 0, T_I32);
    check_state("drain0", mk(0, NOP, 0, 0, 0, 0, T_I32, 0, 0));
    step(1'b0, POP, 0, T_I32);
    check_state("udf", mk(0, NOP, 0, 0, 0, 0, T_I32, 0, 2));
    step(1'b1, NOP, 0, T_I32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
